// File: rtl/pl_inverse_diffusion_pkg.sv
// Shared constants, types and helpers for the Ascon pL inverse block.
package pl_pkg;
  localparam int LANE_W    = 64;
  localparam int NUM_LANES = 5;
  localparam int ROUNDS    = 6;

  // {x0,x1,x2,x3,x4}, x0 in the top 64 bits
  typedef logic [NUM_LANES*LANE_W-1:0] pl_state_t;

  // Right-rotate pairs of the forward Sigma per lane
  localparam logic [5:0] A_ROT [NUM_LANES] = '{6'd19, 6'd61, 6'd1, 6'd10, 6'd7};
  localparam logic [5:0] B_ROT [NUM_LANES] = '{6'd28, 6'd39, 6'd6, 6'd17, 6'd41};

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  // Right rotate; a zero amount shifts the left term out entirely
  function automatic logic [LANE_W-1:0] rotr(input logic [LANE_W-1:0] x, input logic [5:0] s);
    return (x >> s) | (x << (7'd64 - {1'b0, s}));
  endfunction

  // Rotate amount of factor i: (a * 2^i) mod 64
  function automatic logic [5:0] shamt(input logic [5:0] a, input logic [2:0] i);
    return a << i;
  endfunction
endpackage

// File: rtl/pl_inverse_diffusion_if.sv
// Valid/ready handshake bundle for pl_inverse_diffusion.
interface pl_inverse_diffusion_if;
  import pl_pkg::*;
  logic      in_valid;
  logic      in_ready;
  pl_state_t sin;
  logic      out_valid;
  logic      out_ready;
  pl_state_t sout;

  modport slave  (input  in_valid, sin, out_ready, output in_ready, out_valid, sout);
  modport master (output in_valid, sin, out_ready, input  in_ready, out_valid, sout);
endinterface

// File: rtl/pl_inverse_diffusion_sigma_factor.sv
// One factor (I ^ R^a ^ R^b) of the inverse Sigma on a single 64-bit lane.
module pl_sigma_factor
  import pl_pkg::*;
(
  input  logic [LANE_W-1:0] i_x,
  input  logic [5:0]        i_a,
  input  logic [5:0]        i_b,
  output logic [LANE_W-1:0] o_y
);
  assign o_y = i_x ^ rotr(i_x, i_a) ^ rotr(i_x, i_b);
endmodule

// File: rtl/pl_inverse_diffusion.sv
// Iterative inverse of the Ascon pL layer: Sigma^-1 = Sigma^63 is the product
// of six factors (I ^ R^(a*2^i) ^ R^(b*2^i)), UNROLL of them applied per clock.
// UNROLL must divide 6 (1, 2, 3, 6).
// Optional macro PL_INV_FWD_MODE_EN adds a 'fwd' input that selects the forward
// pL (factor 0 only, one-cycle compute).
module pl_inverse_diffusion
  import pl_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic clk,
  input  logic rst_n,
`ifdef PL_INV_FWD_MODE_EN
  input  logic fwd,
`endif
  pl_inverse_diffusion_if.slave s_if
);
  localparam logic [2:0] ROUNDS_C = 3'(ROUNDS);

  fsm_t      r_fsm, w_fsm_nxt;
  pl_state_t r_state;
  logic [2:0] r_rnd;
  logic [2:0] w_rnd_nxt;
  logic       w_last;
  logic       w_rnd_ok;
  pl_state_t  w_result;

  // Combinational factor chain: stage u applies factor r_rnd+u to all lanes
  logic [UNROLL:0][NUM_LANES-1:0][LANE_W-1:0] w_stage;
  assign w_stage[0] = r_state;

  for (genvar u = 0; u < UNROLL; u++) begin : g_unr
    logic [2:0] w_idx;
    assign w_idx = r_rnd + 3'(u);
    for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
      logic [5:0] w_a, w_b;
      assign w_a = shamt(A_ROT[j], w_idx);
      assign w_b = shamt(B_ROT[j], w_idx);
      pl_sigma_factor u_fac (
        .i_x (w_stage[u][NUM_LANES-1-j]),
        .i_a (w_a),
        .i_b (w_b),
        .o_y (w_stage[u+1][NUM_LANES-1-j])
      );
    end
  end

  assign w_rnd_nxt = r_rnd + 3'(UNROLL);
  assign w_rnd_ok  = (r_rnd < ROUNDS_C);

`ifdef PL_INV_FWD_MODE_EN
  logic r_fwd;
  assign w_last   = r_fwd || (w_rnd_nxt >= ROUNDS_C);
  assign w_result = r_fwd ? pl_state_t'(w_stage[1]) : pl_state_t'(w_stage[UNROLL]);
`else
  assign w_last   = (w_rnd_nxt >= ROUNDS_C);
  assign w_result = pl_state_t'(w_stage[UNROLL]);
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fsm <= IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  // Next-state decode; out-of-range round counts fall back to IDLE
  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      IDLE: if (s_if.in_valid) w_fsm_nxt = RUN;
      RUN: begin
        if (!w_rnd_ok)   w_fsm_nxt = IDLE;
        else if (w_last) w_fsm_nxt = DONE;
      end
      DONE: if (s_if.out_ready) w_fsm_nxt = IDLE;
      default: w_fsm_nxt = IDLE;
    endcase
  end

  // Datapath: load on accept, advance one chain per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
      r_rnd   <= '0;
`ifdef PL_INV_FWD_MODE_EN
      r_fwd   <= 1'b0;
`endif
    end else if (r_fsm == IDLE && s_if.in_valid) begin
      r_state <= s_if.sin;
      r_rnd   <= '0;
`ifdef PL_INV_FWD_MODE_EN
      r_fwd   <= fwd;
`endif
    end else if (r_fsm == RUN && w_rnd_ok) begin
      r_state <= w_result;
      r_rnd   <= w_rnd_nxt;
    end
  end

  assign s_if.in_ready  = (r_fsm == IDLE);
  assign s_if.out_valid = (r_fsm == DONE);
  assign s_if.sout      = (r_fsm == DONE) ? r_state : '0;
endmodule

// File: tb/tb_pl_inverse_diffusion.sv
// Directed bench for pl_inverse_diffusion; a forward-pL model provides round-trip
// expectations. Set PL_INV_FWD_MODE_EN to also exercise the forward mode.
module tb_pl_inverse_diffusion;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;

`ifdef PL_INV_FWD_MODE_EN
  logic fwd = 1'b0;
  logic rt_fwd = 1'b0;
`endif

  pl_inverse_diffusion_if m_if ();
  pl_inverse_diffusion #(.UNROLL(1)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef PL_INV_FWD_MODE_EN
    .fwd(fwd),
`endif
    .s_if(m_if));

  // Round-trip instances, one per UNROLL value, fed identical stimulus
  logic         rt_vld = 1'b0;
  logic [319:0] rt_sin = '0;
  pl_inverse_diffusion_if rt1 ();
  pl_inverse_diffusion_if rt2 ();
  pl_inverse_diffusion_if rt3 ();
  pl_inverse_diffusion_if rt6 ();
  assign rt1.in_valid = rt_vld; assign rt1.sin = rt_sin; assign rt1.out_ready = 1'b1;
  assign rt2.in_valid = rt_vld; assign rt2.sin = rt_sin; assign rt2.out_ready = 1'b1;
  assign rt3.in_valid = rt_vld; assign rt3.sin = rt_sin; assign rt3.out_ready = 1'b1;
  assign rt6.in_valid = rt_vld; assign rt6.sin = rt_sin; assign rt6.out_ready = 1'b1;

`ifdef PL_INV_FWD_MODE_EN
  pl_inverse_diffusion #(.UNROLL(1)) d_rt1 (.clk(clk), .rst_n(rst_n), .fwd(rt_fwd), .s_if(rt1));
  pl_inverse_diffusion #(.UNROLL(2)) d_rt2 (.clk(clk), .rst_n(rst_n), .fwd(rt_fwd), .s_if(rt2));
  pl_inverse_diffusion #(.UNROLL(3)) d_rt3 (.clk(clk), .rst_n(rst_n), .fwd(rt_fwd), .s_if(rt3));
  pl_inverse_diffusion #(.UNROLL(6)) d_rt6 (.clk(clk), .rst_n(rst_n), .fwd(rt_fwd), .s_if(rt6));
`else
  pl_inverse_diffusion #(.UNROLL(1)) d_rt1 (.clk(clk), .rst_n(rst_n), .s_if(rt1));
  pl_inverse_diffusion #(.UNROLL(2)) d_rt2 (.clk(clk), .rst_n(rst_n), .s_if(rt2));
  pl_inverse_diffusion #(.UNROLL(3)) d_rt3 (.clk(clk), .rst_n(rst_n), .s_if(rt3));
  pl_inverse_diffusion #(.UNROLL(6)) d_rt6 (.clk(clk), .rst_n(rst_n), .s_if(rt6));
`endif

  logic [3:0]   rt_ov;
  logic [319:0] rt_so [4];
  assign rt_ov = {rt6.out_valid, rt3.out_valid, rt2.out_valid, rt1.out_valid};
  assign rt_so[0] = rt1.sout;
  assign rt_so[1] = rt2.sout;
  assign rt_so[2] = rt3.sout;
  assign rt_so[3] = rt6.sout;

  // Forward Ascon pL: x ^ ROTR(x,a) ^ ROTR(x,b) per lane
  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] fwd_model(input logic [319:0] s);
    int ra [5] = '{19, 61, 1, 10, 7};
    int rb [5] = '{28, 39, 6, 17, 41};
    logic [319:0] r;
    logic [63:0]  x;
    r = '0;
    for (int j = 0; j < 5; j++) begin
      x = s[(4-j)*64 +: 64];
      r[(4-j)*64 +: 64] = x ^ ror(x, ra[j]) ^ ror(x, rb[j]);
    end
    return r;
  endfunction

  function automatic logic [319:0] rand_state();
    logic [319:0] r;
    for (int k = 0; k < 10; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Accept one state on the main DUT; returns cycles to out_valid (0 = timeout)
  task automatic run_one(input logic [319:0] s, output int lat, output logic [319:0] res);
    @(negedge clk);
    m_if.sin = s; m_if.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_if.in_valid = 1'b0;
    lat = 0; res = '0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (m_if.out_valid) begin lat = k; res = m_if.sout; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m_if.in_valid = 1'b0; m_if.out_ready = 1'b0; m_if.sin = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tot++; if (m_if.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ovalid got=%b exp=0", m_if.out_valid); end
    n_tot++; if (m_if.sout !== '0) begin n_bad++; $display("FAIL reset_sout got=%h exp=0", m_if.sout); end
    rst_n = 1'b1;
    @(negedge clk);
    n_tot++; if (m_if.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_iready got=%b exp=1", m_if.in_ready); end
  endtask

  task automatic test_zero();
    int lat; logic rdy_seen;
    m_if.out_ready = 1'b1;
    @(negedge clk);
    m_if.sin = '0; m_if.in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    m_if.in_valid = 1'b0;
    lat = 0; rdy_seen = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (m_if.in_ready !== 1'b0) rdy_seen = 1'b1;
      @(posedge clk); @(negedge clk);
      if (m_if.out_valid) begin
        if (m_if.in_ready !== 1'b0) rdy_seen = 1'b1;
        lat = k;
        n_tot++; if (m_if.sout !== '0) begin n_bad++; $display("FAIL zero_sout got=%h exp=0", m_if.sout); end
        break;
      end
    end
    n_tot++; if (lat !== 6) begin n_bad++; $display("FAIL zero_latency got=%0d exp=6", lat); end
    n_tot++; if (rdy_seen !== 1'b0) begin n_bad++; $display("FAIL zero_iready_busy got=1 exp=0"); end
  endtask

  task automatic test_single_lane();
    int lat; logic [319:0] res;
    m_if.out_ready = 1'b1;
    run_one({256'h0, 64'h0200_0000_0080_0001}, lat, res);
    n_tot++; if (res !== {256'h0, 64'h1}) begin n_bad++; $display("FAIL lane4_unit got=%h exp=%h", res, {256'h0, 64'h1}); end
    n_tot++; if (lat !== 6) begin n_bad++; $display("FAIL lane4_latency got=%0d exp=6", lat); end
    run_one({128'h0, 64'h8400_0000_0000_0001, 128'h0}, lat, res);
    n_tot++; if (res !== {128'h0, 64'h1, 128'h0}) begin n_bad++; $display("FAIL lane2_unit got=%h exp=%h", res, {128'h0, 64'h1, 128'h0}); end
  endtask

  task automatic test_round_trip();
    int exp_lat [4] = '{6, 3, 2, 1};
    int lat [4];
    logic [319:0] res [4];
    logic [319:0] orig;
    for (int n = 0; n < 1000; n++) begin
      orig = rand_state();
      @(negedge clk);
      rt_sin = fwd_model(orig); rt_vld = 1'b1;
      @(posedge clk); @(negedge clk);
      rt_vld = 1'b0;
      for (int d = 0; d < 4; d++) begin lat[d] = 0; res[d] = '0; end
      for (int k = 1; k <= 8; k++) begin
        @(posedge clk); @(negedge clk);
        for (int d = 0; d < 4; d++)
          if (rt_ov[d] && lat[d] == 0) begin lat[d] = k; res[d] = rt_so[d]; end
      end
      for (int d = 0; d < 4; d++) begin
        n_tot++; if (lat[d] !== exp_lat[d]) begin n_bad++; $display("FAIL rt_latency inst=%0d got=%0d exp=%0d", d, lat[d], exp_lat[d]); end
        n_tot++; if (res[d] !== orig) begin n_bad++; $display("FAIL rt_data inst=%0d got=%h exp=%h", d, res[d], orig); end
      end
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [319:0] res; logic [319:0] exp_s;
    exp_s = {256'h0, 64'h1};
    m_if.out_ready = 1'b0;
    run_one({256'h0, 64'h0200_0000_0080_0001}, lat, res);
    n_tot++; if (lat !== 6) begin n_bad++; $display("FAIL bp_latency got=%0d exp=6", lat); end
    for (int k = 0; k < 20; k++) begin
      m_if.in_valid = k[0]; m_if.sin = rand_state();
      @(posedge clk); @(negedge clk);
      n_tot++; if (m_if.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_ovalid cyc=%0d got=%b exp=1", k, m_if.out_valid); end
      n_tot++; if (m_if.sout !== exp_s) begin n_bad++; $display("FAIL bp_sout cyc=%0d got=%h exp=%h", k, m_if.sout, exp_s); end
      n_tot++; if (m_if.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_iready cyc=%0d got=%b exp=0", k, m_if.in_ready); end
    end
    m_if.in_valid = 1'b0; m_if.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    n_tot++; if (m_if.out_valid !== 1'b0 || m_if.in_ready !== 1'b1)
      begin n_bad++; $display("FAIL bp_release ovalid=%b iready=%b exp=0/1", m_if.out_valid, m_if.in_ready); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [319:0] res; logic [319:0] orig;
    m_if.out_ready = 1'b1;
    @(negedge clk);
    m_if.sin = fwd_model(rand_state()); m_if.in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    m_if.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tot++; if (m_if.in_ready !== 1'b1 || m_if.out_valid !== 1'b0)
      begin n_bad++; $display("FAIL rst_run iready=%b ovalid=%b exp=1/0", m_if.in_ready, m_if.out_valid); end
    @(negedge clk); rst_n = 1'b1;
    // Reset while holding a result in DONE
    m_if.out_ready = 1'b0;
    run_one({256'h0, 64'h0200_0000_0080_0001}, lat, res);
    n_tot++; if (m_if.out_valid !== 1'b1) begin n_bad++; $display("FAIL rst_pre_done got=%b exp=1", m_if.out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_tot++; if (m_if.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_done_ovalid got=%b exp=0", m_if.out_valid); end
    n_tot++; if (m_if.sout !== '0) begin n_bad++; $display("FAIL rst_done_sout got=%h exp=0", m_if.sout); end
    // in_valid already high on the first IDLE cycle after release
    orig = rand_state();
    m_if.out_ready = 1'b1;
    m_if.sin = fwd_model(orig); m_if.in_valid = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    m_if.in_valid = 1'b0;
    lat = 0; res = '0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (m_if.out_valid) begin lat = k; res = m_if.sout; break; end
    end
    n_tot++; if (lat !== 6) begin n_bad++; $display("FAIL rst_after_latency got=%0d exp=6", lat); end
    n_tot++; if (res !== orig) begin n_bad++; $display("FAIL rst_after_data got=%h exp=%h", res, orig); end
  endtask

`ifdef PL_INV_FWD_MODE_EN
  task automatic test_fwd();
    int lat; logic [319:0] res;
    m_if.out_ready = 1'b1;
    fwd = 1'b1;
    run_one({256'h0, 64'h1}, lat, res);
    fwd = 1'b0;
    n_tot++; if (lat !== 1) begin n_bad++; $display("FAIL fwd_latency got=%0d exp=1", lat); end
    n_tot++; if (res !== {256'h0, 64'h0200_0000_0080_0001})
      begin n_bad++; $display("FAIL fwd_data got=%h exp=%h", res, {256'h0, 64'h0200_0000_0080_0001}); end
  endtask
`endif

  initial begin
    test_reset();
    test_zero();
    test_single_lane();
    test_round_trip();
    test_backpressure();
    test_reset_mid();
`ifdef PL_INV_FWD_MODE_EN
    test_fwd();
`endif
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
